// File: rtl/mx_vector_sign_if.sv
// Handshake bundle for the MX vector sign unit: block input channel and result channel.
// Both channels are valid/ready; the unit is the slave on both.
interface mx_vector_sign_if #(
  parameter int BLOCK_SIZE = 32,
  parameter int ELEM_W     = 8,
  parameter int SCALE_W    = 8
);
  localparam int CNT_W = $clog2(BLOCK_SIZE + 1);

  logic                         in_valid;
  logic                         in_ready;
  logic [1:0]                   in_mode;
  logic [SCALE_W-1:0]           in_scale;
  logic [BLOCK_SIZE*ELEM_W-1:0] in_elements;
  logic                         out_valid;
  logic                         out_ready;
  logic [SCALE_W-1:0]           out_scale;
  logic [BLOCK_SIZE*ELEM_W-1:0] out_elements;
  logic [CNT_W-1:0]             out_sat_count;

  modport master (
    output in_valid, in_mode, in_scale, in_elements, out_ready,
    input  in_ready, out_valid, out_scale, out_elements, out_sat_count
  );

  modport slave (
    input  in_valid, in_mode, in_scale, in_elements, out_ready,
    output in_ready, out_valid, out_scale, out_elements, out_sat_count
  );
endinterface

// File: rtl/mx_vector_sign_unit.sv
// Multi-cycle pass/negate/abs unit for one MXINT block, LANES elements per beat,
// with optional saturation of the most-negative code and a per-block saturation count.
module mx_vector_sign_unit #(
  parameter int BLOCK_SIZE = 32,
  parameter int ELEM_W     = 8,
  parameter int SCALE_W    = 8,
  parameter int LANES      = 8,
  parameter bit SATURATE   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  mx_vector_sign_if.slave  bus
);
  localparam int BEATS  = BLOCK_SIZE / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W  = $clog2(BLOCK_SIZE + 1);
  localparam int VEC_W  = BLOCK_SIZE * ELEM_W;
  localparam int SLICE_W = LANES * ELEM_W;

  localparam logic [ELEM_W-1:0] MIN_CODE  = {1'b1, {(ELEM_W-1){1'b0}}};
  localparam logic [ELEM_W-1:0] MAX_CODE  = {1'b0, {(ELEM_W-1){1'b1}}};
  localparam logic [ELEM_W-1:0] MIN_NEG   = SATURATE ? MAX_CODE : MIN_CODE;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_reg, state_next;
  logic [BEAT_W-1:0]   beat_reg;
  logic                in_ready_reg;
  logic [1:0]          mode_reg;
  logic [SCALE_W-1:0]  scale_reg, out_scale_reg;
  logic [VEC_W-1:0]    src_reg, work_reg, work_next, out_elements_reg;
  logic [CNT_W-1:0]    sat_acc_reg, sat_acc_next, out_sat_reg;
  logic [SLICE_W-1:0]  lane_in, lane_out;
  logic [LANES-1:0]    lane_sat;
  logic                accept, last_beat;

  // in_ready is only ever high in IDLE, so it alone qualifies the handshake
  assign accept    = bus.in_valid && in_ready_reg;
  assign last_beat = (beat_reg == LAST_BEAT);
  assign lane_in   = src_reg[int'(beat_reg)*SLICE_W +: SLICE_W];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [ELEM_W-1:0] x, neg_x;
    logic              do_neg, is_min;

    assign x      = lane_in[gi*ELEM_W +: ELEM_W];
    assign neg_x  = ~x + ELEM_W'(1);
    assign is_min = (x == MIN_CODE);
    assign do_neg = (mode_reg == 2'b01) || ((mode_reg == 2'b10) && x[ELEM_W-1]);
    assign lane_sat[gi] = do_neg && is_min;
    assign lane_out[gi*ELEM_W +: ELEM_W] = !do_neg ? x : (is_min ? MIN_NEG : neg_x);
  end

  always_comb begin
    work_next = work_reg;
    work_next[int'(beat_reg)*SLICE_W +: SLICE_W] = lane_out;
    sat_acc_next = sat_acc_reg;
    for (int i = 0; i < LANES; i++) begin
      sat_acc_next = sat_acc_next + CNT_W'(lane_sat[i]);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)        state_next = BUSY;
      BUSY:    if (last_beat)     state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      beat_reg         <= '0;
      in_ready_reg     <= 1'b0;
      mode_reg         <= '0;
      scale_reg        <= '0;
      src_reg          <= '0;
      work_reg         <= '0;
      sat_acc_reg      <= '0;
      out_scale_reg    <= '0;
      out_elements_reg <= '0;
      out_sat_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next == IDLE);
      case (state_reg)
        IDLE: begin
          if (accept) begin
            mode_reg    <= bus.in_mode;
            scale_reg   <= bus.in_scale;
            src_reg     <= bus.in_elements;
            sat_acc_reg <= '0;
            beat_reg    <= '0;
          end
        end
        BUSY: begin
          work_reg    <= work_next;
          sat_acc_reg <= sat_acc_next;
          beat_reg    <= last_beat ? '0 : beat_reg + BEAT_W'(1);
          // Results are published only once the block is complete, so the
          // previous block's outputs stay visible while this one is worked on
          if (last_beat) begin
            out_elements_reg <= work_next;
            out_sat_reg      <= sat_acc_next;
            out_scale_reg    <= scale_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready      = in_ready_reg;
  assign bus.out_valid     = (state_reg == DONE);
  assign bus.out_scale     = out_scale_reg;
  assign bus.out_elements  = out_elements_reg;
  assign bus.out_sat_count = out_sat_reg;
endmodule

// File: tb/tb_mx_vector_sign_unit.sv
// Scoreboard bench for mx_vector_sign_unit: default build plus a BEATS=1 non-saturating
// build and a LANES=1, 4-bit build, each with its own expectation queue and monitor.
module tb_mx_vector_sign_unit;
  logic clk;
  logic rst_n;
  int   ncyc;
  int   checks;
  int   errors;

  typedef struct {
    logic [7:0]   scale;
    logic [255:0] elems;
    int           sat;
    int           acc;
    int           lat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  logic [255:0] el, ex, ex2;

  mx_vector_sign_if #(.BLOCK_SIZE(32), .ELEM_W(8), .SCALE_W(8)) a_if ();
  mx_vector_sign_if #(.BLOCK_SIZE(32), .ELEM_W(8), .SCALE_W(8)) b_if ();
  mx_vector_sign_if #(.BLOCK_SIZE(32), .ELEM_W(4), .SCALE_W(8)) c_if ();

  mx_vector_sign_unit #(.BLOCK_SIZE(32), .ELEM_W(8), .SCALE_W(8), .LANES(8), .SATURATE(1'b1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  mx_vector_sign_unit #(.BLOCK_SIZE(32), .ELEM_W(8), .SCALE_W(8), .LANES(32), .SATURATE(1'b0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
  mx_vector_sign_unit #(.BLOCK_SIZE(32), .ELEM_W(4), .SCALE_W(8), .LANES(1), .SATURATE(1'b1))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(c_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  function automatic void chk(string name, logic [255:0] got, logic [255:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endfunction

  function automatic bit ready_of(int which);
    case (which)
      0:       return a_if.in_ready;
      1:       return b_if.in_ready;
      default: return c_if.in_ready;
    endcase
  endfunction

  task automatic drive(int which, bit v, logic [1:0] m, logic [7:0] s, logic [255:0] e);
    case (which)
      0: begin a_if.in_valid = v; a_if.in_mode = m; a_if.in_scale = s; a_if.in_elements = e; end
      1: begin b_if.in_valid = v; b_if.in_mode = m; b_if.in_scale = s; b_if.in_elements = e; end
      default: begin
        c_if.in_valid = v; c_if.in_mode = m; c_if.in_scale = s; c_if.in_elements = e[127:0];
      end
    endcase
  endtask

  // Present a block, wait (bounded) for acceptance, queue its expectation,
  // then scribble the data inputs to show they are ignored after the handshake.
  task automatic send(int which, logic [1:0] m, logic [7:0] s, logic [255:0] e,
                      logic [255:0] exp_el, int exp_sat, int lat);
    exp_t x;
    int   w;
    w = 0;
    @(negedge clk);
    drive(which, 1'b1, m, s, e);
    while (!ready_of(which) && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("accept_wait", 256'(ready_of(which)), 256'(1));
    if (ready_of(which)) begin
      x = '{scale: s, elems: exp_el, sat: exp_sat, acc: ncyc, lat: lat};
      case (which)
        0:       qa.push_back(x);
        1:       qb.push_back(x);
        default: qc.push_back(x);
      endcase
    end
    @(negedge clk);
    drive(which, 1'b0, 2'b01, ~s, ~e);
  endtask

  task automatic check_out(string tag, exp_t e, logic [7:0] sc, logic [255:0] oe, int sat, bit first);
    chk({tag, "_scale"}, 256'(sc), 256'(e.scale));
    chk({tag, "_elems"}, oe, e.elems);
    chk({tag, "_sat"}, 256'(sat), 256'(e.sat));
    if (first) begin
      chk({tag, "_latency"}, 256'(ncyc - e.acc), 256'(e.lat));
      $display("block %s accepted@%0d latency=%0d scale=%02h sat=%0d elems=%0h",
               tag, e.acc, ncyc - e.acc, sc, sat, oe);
    end
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((qa.size() + qb.size() + qc.size()) != 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    chk("drain", 256'(qa.size() + qb.size() + qc.size()), 256'(0));
  endtask

  initial begin : mon_a
    exp_t e;
    bit   prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (a_if.out_valid && !prev) begin
        chk("a_pending", 256'(qa.size() > 0), 256'(1));
        if (qa.size() > 0) begin
          e = qa.pop_front();
          check_out("a", e, a_if.out_scale, 256'(a_if.out_elements), int'(a_if.out_sat_count), 1'b1);
        end
      end else if (a_if.out_valid) begin
        check_out("a_hold", e, a_if.out_scale, 256'(a_if.out_elements), int'(a_if.out_sat_count), 1'b0);
      end
      prev = a_if.out_valid;
    end
  end

  initial begin : mon_b
    exp_t e;
    bit   prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (b_if.out_valid && !prev) begin
        chk("b_pending", 256'(qb.size() > 0), 256'(1));
        if (qb.size() > 0) begin
          e = qb.pop_front();
          check_out("b", e, b_if.out_scale, 256'(b_if.out_elements), int'(b_if.out_sat_count), 1'b1);
        end
      end
      prev = b_if.out_valid;
    end
  end

  initial begin : mon_c
    exp_t e;
    bit   prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (c_if.out_valid && !prev) begin
        chk("c_pending", 256'(qc.size() > 0), 256'(1));
        if (qc.size() > 0) begin
          e = qc.pop_front();
          check_out("c", e, c_if.out_scale, 256'(c_if.out_elements), int'(c_if.out_sat_count), 1'b1);
        end
      end
      prev = c_if.out_valid;
    end
  end

  initial begin : stim
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    drive(0, 1'b0, 2'b00, 8'h00, '0);
    drive(1, 1'b0, 2'b00, 8'h00, '0);
    drive(2, 1'b0, 2'b00, 8'h00, '0);
    a_if.out_ready = 1'b1;
    b_if.out_ready = 1'b1;
    c_if.out_ready = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 256'(a_if.in_ready), 256'(0));
    chk("rst_out_valid", 256'(a_if.out_valid), 256'(0));
    chk("rst_out_scale", 256'(a_if.out_scale), 256'(0));
    chk("rst_out_elems", 256'(a_if.out_elements), 256'(0));
    chk("rst_out_sat", 256'(a_if.out_sat_count), 256'(0));
    rst_n = 1'b1;
    #1 chk("in_ready_before_edge", 256'(a_if.in_ready), 256'(0));
    @(negedge clk);
    chk("in_ready_after_edge", 256'(a_if.in_ready), 256'(1));

    // Negate i-16 with element 0 forced to -128 (saturates to 127)
    el = '0; ex = '0;
    for (int i = 0; i < 32; i++) begin
      el[i*8 +: 8] = 8'(i - 16);
      ex[i*8 +: 8] = 8'(16 - i);
    end
    el[7:0] = 8'h80;
    ex[7:0] = 8'h7F;
    send(0, 2'b01, 8'h7F, el, ex, 1, 5);

    // Abs of -128/-1/0/5, saturating and wrapping builds
    for (int j = 0; j < 8; j++) begin
      el[j*32 +: 32]  = 32'h05_00_FF_80;
      ex[j*32 +: 32]  = 32'h05_00_01_7F;
      ex2[j*32 +: 32] = 32'h05_00_01_80;
    end
    send(0, 2'b10, 8'h01, el, ex, 8, 5);
    send(1, 2'b10, 8'h02, el, ex2, 8, 2);

    // Pass and mode 11 with NaN scale
    for (int j = 0; j < 8; j++) el[j*32 +: 32] = $urandom;
    send(0, 2'b00, 8'hFF, el, el, 0, 5);
    for (int j = 0; j < 8; j++) el[j*32 +: 32] = $urandom;
    el[15:8] = 8'h80;
    send(0, 2'b11, 8'hFF, el, el, 0, 5);

    // 4-bit, one lane: -8 negates to 7, ones become -1
    el = '0; ex = '0;
    for (int i = 0; i < 32; i++) begin
      el[i*4 +: 4] = 4'h1;
      ex[i*4 +: 4] = 4'hF;
    end
    el[3:0] = 4'h8;
    ex[3:0] = 4'h7;
    send(2, 2'b01, 8'h10, el, ex, 1, 33);
    wait_drain();

    // Back-pressure: first result held 10 cycles while a second block waits
    a_if.out_ready = 1'b0;
    for (int j = 0; j < 32; j++) begin
      el[j*8 +: 8] = 8'h03;
      ex[j*8 +: 8] = 8'hFD;
    end
    send(0, 2'b01, 8'h33, el, ex, 0, 5);
    for (int j = 0; j < 32; j++) begin
      el[j*8 +: 8] = 8'hF9;
      ex[j*8 +: 8] = 8'h07;
    end
    fork
      send(0, 2'b10, 8'h44, el, ex, 0, 5);
      begin
        int w;
        w = 0;
        while (!a_if.out_valid && w < 50) begin
          @(negedge clk);
          w++;
        end
        chk("bp_valid_seen", 256'(a_if.out_valid), 256'(1));
        repeat (10) begin
          @(negedge clk);
          chk("bp_in_ready_low", 256'(a_if.in_ready), 256'(0));
          chk("bp_valid_held", 256'(a_if.out_valid), 256'(1));
        end
        a_if.out_ready = 1'b1;
      end
    join
    wait_drain();

    // Asynchronous reset while at beat 2 of a block
    for (int j = 0; j < 32; j++) el[j*8 +: 8] = 8'h21;
    send(0, 2'b01, 8'h55, el, el, 0, 5);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 256'(a_if.out_valid), 256'(0));
    chk("abort_in_ready", 256'(a_if.in_ready), 256'(0));
    chk("abort_out_scale", 256'(a_if.out_scale), 256'(0));
    chk("abort_out_elems", 256'(a_if.out_elements), 256'(0));
    chk("abort_out_sat", 256'(a_if.out_sat_count), 256'(0));
    qa.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("abort_no_valid", 256'(a_if.out_valid), 256'(0));
    end

    // Recovery: all most-negative codes, count hits the block size
    for (int j = 0; j < 32; j++) begin
      el[j*8 +: 8] = 8'h80;
      ex[j*8 +: 8] = 8'h7F;
    end
    send(0, 2'b01, 8'h66, el, ex, 32, 5);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
